// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and buffers one fetched instruction for the IF/ID pipeline registers.
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_plus4,
   output logic [31:0]     if_inst,
   output logic            ifid_load
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, KILL} state_t;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [31:0]     if_inst_q, if_inst_d;
   logic            if_valid_q, if_valid_d;
   logic [XLEN-1:0] redirect_tgt;
   logic            buf_free;

   assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
   assign ifid_load    = if_valid_q & ~stall & ~redirect;
   assign buf_free     = ~if_valid_q | ifid_load;
   // WAIT and KILL keep the request asserted so the address stays stable until ack.
   assign imem_req     = ((state_q == FETCH) & buf_free & ~redirect)
                       | (state_q == WAIT) | (state_q == KILL);
   assign imem_addr    = (state_q == FETCH) ? pc_q : req_addr_q;
   assign if_valid     = if_valid_q;
   assign if_pc        = if_pc_q;
   assign if_inst      = if_inst_q;
   assign if_pc_plus4  = if_pc_q + PC_STEP;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_valid_d = if_valid_q & ~ifid_load;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               pc_d       = redirect_tgt;
               if_valid_d = 1'b0;
            end else if (imem_req && imem_ack) begin
               if_valid_d = 1'b1;
               if_pc_d    = pc_q;
               if_inst_d  = imem_rdata;
               pc_d       = pc_q + PC_STEP;
            end else if (imem_req) begin
               req_addr_d = pc_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            // A redirect with no ack yet leaves a stale response to swallow in KILL.
            if (redirect) begin
               pc_d       = redirect_tgt;
               if_valid_d = 1'b0;
               state_d    = imem_ack ? FETCH : KILL;
            end else if (imem_ack) begin
               if_valid_d = 1'b1;
               if_pc_d    = req_addr_q;
               if_inst_d  = imem_rdata;
               pc_d       = req_addr_q + PC_STEP;
               state_d    = FETCH;
            end
         end
         KILL: begin
            if (redirect) begin
               pc_d = redirect_tgt;
            end
            if (imem_ack) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_valid_q <= if_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a scoreboard of expected delivered PCs plus per-scenario inline checks;
// a second instance with RESET_PC=32'hFFFF_FFFC covers address wrap and mid-request reset.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        zw = 1'b1;
   logic        ack_drv = 1'b0;
   logic        imem_req, imem_ack, if_valid, ifid_load;
   logic [31:0] imem_addr, imem_rdata, if_pc, if_pc_plus4, if_inst;

   logic        rst_w = 1'b1;
   logic        zw_w = 1'b1;
   logic        ack_drv_w = 1'b0;
   logic        imem_req_w, imem_ack_w, if_valid_w, ifid_load_w;
   logic [31:0] imem_addr_w, imem_rdata_w, if_pc_w, if_pc_plus4_w, if_inst_w;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   // Memory model: zero-wait mode answers every request at once, otherwise the bench drives ack.
   assign imem_ack     = zw ? imem_req : ack_drv;
   assign imem_rdata   = imem_addr ^ KEY;
   assign imem_ack_w   = zw_w ? imem_req_w : ack_drv_w;
   assign imem_rdata_w = imem_addr_w ^ KEY;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst),
      .ifid_load(ifid_load)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst_w), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
      .if_valid(if_valid_w), .if_pc(if_pc_w), .if_pc_plus4(if_pc_plus4_w), .if_inst(if_inst_w),
      .ifid_load(ifid_load_w)
   );

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || ifid_load !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_req: req=%b load=%b expected 0 0", imem_req, ifid_load);
      end
      checks++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_buf: valid=%b pc=%h inst=%h expected 0 0 0", if_valid, if_pc, if_inst);
      end
      checks++;
      if (imem_addr !== 32'h0 || if_pc_plus4 !== 32'h4) begin
         errors++; $display("[TB] FAIL reset_addr: addr=%h pc4=%h expected 0 4", imem_addr, if_pc_plus4);
      end
      checks++;
      if (imem_req_w !== 1'b0 || if_pc_w !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_wrap_inst: req=%b pc=%h expected 0 0", imem_req_w, if_pc_w);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_wait();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ifid_load === 1'b1) begin
            if (sb_q.size() != 0) exp_pc = sb_q.pop_front(); else exp_pc = 'x;
            checks++;
            if (if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY) || if_pc_plus4 !== exp_pc + 32'd4) begin
               errors++; $display("[TB] FAIL sb_zw: pc=%h inst=%h expected pc=%h", if_pc, if_inst, exp_pc);
            end
         end
         checks++;
         if (imem_req !== (i >= 1)) begin
            errors++; $display("[TB] FAIL zw_req cycle %0d: got %b expected %b", i, imem_req, (i >= 1));
         end
         checks++;
         if (if_valid !== (i >= 2) || ifid_load !== (i >= 2)) begin
            errors++; $display("[TB] FAIL zw_valid cycle %0d: valid=%b load=%b expected %b", i, if_valid, ifid_load, (i >= 2));
         end
         if (i >= 1) begin
            checks++;
            if (imem_addr !== 32'(4 * (i - 1))) begin
               errors++; $display("[TB] FAIL zw_addr cycle %0d: got %h expected %h", i, imem_addr, 32'(4 * (i - 1)));
            end
            sb_q.push_back(32'(4 * (i - 1)));
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_latency();
      logic [31:0] a;
      zw = 1'b0;
      for (int r = 0; r < 3; r++) begin
         a = 32'd28 + 32'(4 * r);
         for (int k = 0; k < 3; k++) begin
            if (k == 2) ack_drv = 1'b1;
            @(negedge clk);
            if (ifid_load === 1'b1) begin
               if (sb_q.size() != 0) exp_pc = sb_q.pop_front(); else exp_pc = 'x;
               checks++;
               if (if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY) || if_pc_plus4 !== exp_pc + 32'd4) begin
                  errors++; $display("[TB] FAIL sb_lat: pc=%h inst=%h expected pc=%h", if_pc, if_inst, exp_pc);
               end
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
               errors++; $display("[TB] FAIL lat_req r%0d k%0d: req=%b addr=%h expected 1 %h", r, k, imem_req, imem_addr, a);
            end
            if (k == 2) sb_q.push_back(a);
            @(posedge clk);
            #1;
         end
         ack_drv = 1'b0;
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (ifid_load !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_req cycle %0d: load=%b req=%b expected 0 0", k, ifid_load, imem_req);
         end
         checks++;
         if (if_valid !== 1'b1 || if_pc !== 32'd36 || if_inst !== (32'd36 ^ KEY)) begin
            errors++; $display("[TB] FAIL stall_hold cycle %0d: valid=%b pc=%h inst=%h expected 1 00000024", k, if_valid, if_pc, if_inst);
         end
         @(posedge clk);
         #1;
      end
      stall = 1'b0;
      zw = 1'b1;
      @(negedge clk);
      if (ifid_load === 1'b1) begin
         if (sb_q.size() != 0) exp_pc = sb_q.pop_front(); else exp_pc = 'x;
         checks++;
         if (if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY)) begin
            errors++; $display("[TB] FAIL sb_stall: pc=%h inst=%h expected pc=%h", if_pc, if_inst, exp_pc);
         end
      end
      checks++;
      if (ifid_load !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'd40) begin
         errors++; $display("[TB] FAIL stall_release: load=%b req=%b addr=%h expected 1 1 00000028", ifid_load, imem_req, imem_addr);
      end
      sb_q.push_back(32'd40);
      @(posedge clk);
      #1;
   endtask

   task automatic test_redirect_wait();
      zw = 1'b0;
      @(negedge clk);
      if (ifid_load === 1'b1) begin
         if (sb_q.size() != 0) exp_pc = sb_q.pop_front(); else exp_pc = 'x;
         checks++;
         if (if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY)) begin
            errors++; $display("[TB] FAIL sb_rw: pc=%h inst=%h expected pc=%h", if_pc, if_inst, exp_pc);
         end
      end
      @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'd44 || if_valid !== 1'b0 || ifid_load !== 1'b0) begin
            errors++; $display("[TB] FAIL rw_kill cycle %0d: req=%b addr=%h valid=%b load=%b expected 1 0000002c 0 0",
                               k, imem_req, imem_addr, if_valid, ifid_load);
         end
         @(posedge clk);
         #1;
         redirect = 1'b0;
         if (k == 1) ack_drv = 1'b1;
      end
      ack_drv = 1'b0;
      zw = 1'b1;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
         errors++; $display("[TB] FAIL rw_refetch: valid=%b req=%b addr=%h expected 0 1 00000100", if_valid, imem_req, imem_addr);
      end
      sb_q.push_back(32'h0000_0100);
      @(posedge clk);
      #1;
      @(negedge clk);
      if (sb_q.size() != 0) exp_pc = sb_q.pop_front(); else exp_pc = 'x;
      checks++;
      if (ifid_load !== 1'b1 || if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY)) begin
         errors++; $display("[TB] FAIL sb_rw_target: load=%b pc=%h inst=%h expected 1 %h", ifid_load, if_pc, if_inst, exp_pc);
      end
      sb_q.push_back(32'h0000_0104);
      @(posedge clk);
      #1;
   endtask

   task automatic test_redirect_fetch();
      zw = 1'b0;
      ack_drv = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      checks++;
      if (ifid_load !== 1'b0 || imem_req !== 1'b0) begin
         errors++; $display("[TB] FAIL rf_squash: load=%b req=%b expected 0 0", ifid_load, imem_req);
      end
      sb_q.delete();
      @(posedge clk);
      #1;
      redirect = 1'b0;
      ack_drv = 1'b0;
      zw = 1'b1;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
         errors++; $display("[TB] FAIL rf_refetch: valid=%b req=%b addr=%h expected 0 1 00000200", if_valid, imem_req, imem_addr);
      end
      sb_q.push_back(32'h0000_0200);
      @(posedge clk);
      #1;
      @(negedge clk);
      if (sb_q.size() != 0) exp_pc = sb_q.pop_front(); else exp_pc = 'x;
      checks++;
      if (ifid_load !== 1'b1 || if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY)) begin
         errors++; $display("[TB] FAIL sb_rf_target: load=%b pc=%h inst=%h expected 1 %h", ifid_load, if_pc, if_inst, exp_pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap_and_reset();
      rst_w = 1'b0;
      @(negedge clk);
      checks++;
      if (imem_req_w !== 1'b0) begin
         errors++; $display("[TB] FAIL wrap_idle: req=%b expected 0", imem_req_w);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC) begin
         errors++; $display("[TB] FAIL wrap_first: req=%b addr=%h expected 1 fffffffc", imem_req_w, imem_addr_w);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (if_valid_w !== 1'b1 || if_pc_w !== 32'hFFFF_FFFC || if_inst_w !== (32'hFFFF_FFFC ^ KEY) || if_pc_plus4_w !== 32'h0) begin
         errors++; $display("[TB] FAIL wrap_buf: valid=%b pc=%h inst=%h pc4=%h expected 1 fffffffc 5a5a5a59 0",
                            if_valid_w, if_pc_w, if_inst_w, if_pc_plus4_w);
      end
      checks++;
      if (imem_addr_w !== 32'h0) begin
         errors++; $display("[TB] FAIL wrap_second: addr=%h expected 0", imem_addr_w);
      end
      @(posedge clk);
      #1;
      zw_w = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (imem_req_w !== 1'b1 || imem_addr_w !== 32'h4) begin
            errors++; $display("[TB] FAIL wrap_pending: req=%b addr=%h expected 1 4", imem_req_w, imem_addr_w);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #2;
      rst_w = 1'b1;
      #1;
      checks++;
      if (imem_req_w !== 1'b0 || if_valid_w !== 1'b0 || if_pc_w !== 32'h0 || if_inst_w !== 32'h0 ||
          imem_addr_w !== 32'h0 || ifid_load_w !== 1'b0) begin
         errors++; $display("[TB] FAIL midwait_reset: req=%b valid=%b pc=%h inst=%h addr=%h load=%b expected all 0",
                            imem_req_w, if_valid_w, if_pc_w, if_inst_w, imem_addr_w, ifid_load_w);
      end
      ack_drv_w = 1'b1;
      @(posedge clk);
      #1;
      rst_w = 1'b0;
      @(posedge clk);
      #1;
      ack_drv_w = 1'b0;
      @(negedge clk);
      checks++;
      if (if_valid_w !== 1'b0) begin
         errors++; $display("[TB] FAIL stale_ack_idle: valid=%b expected 0", if_valid_w);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_latency();
      test_stall();
      test_redirect_wait();
      test_redirect_fetch();
      test_wrap_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
